// File: rtl/memory.sv
// memory: load/store stage between execute and writeback.
// Issues one access at a time on a req/ack bus, aligns and extends load data,
// and forwards the control bundle to writeback.
// Optional feature macro: MEMORY_MISALIGNED_EXCEPTION_EN (misaligned half/word
// accesses raise an exception instead of going to the bus).
//
// Bus handshake: mem_req rises on the issue edge and, together with mem_addr,
// mem_we, mem_wdata and mem_byte_enable, stays constant up to and including
// the cycle in which mem_ack is high; mem_rdata is sampled only in that cycle.
// Only one access is ever outstanding.
module memory (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] csr_data_in,
  input  logic        branch_taken_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic        load_signed_in,
  input  logic        csr_write_in,
  input  logic        mret_in,
  input  logic        wfi_in,
  input  logic        valid_in,
  input  logic        exception_in,
  input  logic [1:0]  load_store_size_in,
  input  logic [1:0]  write_select_in,
  input  logic [4:0]  rd_address_in,
  input  logic [11:0] csr_address_in,
  input  logic [3:0]  ecause_in,
  input  logic        stall,
  input  logic        invalidate,
  output logic        mem_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] csr_data_out,
  output logic [31:0] load_data_out,
  output logic        branch_taken_out,
  output logic        csr_write_out,
  output logic        mret_out,
  output logic        wfi_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [1:0]  write_select_out,
  output logic [4:0]  rd_address_out,
  output logic [11:0] csr_address_out,
  output logic [3:0]  ecause_out,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_misaligned;
  logic        w_access;
  logic        w_retire;
  logic        w_issue;
  logic        w_pass;
  logic        w_done;
  logic        w_hold;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [31:0] w_lane;
  logic [31:0] w_load_data;
  logic        w_exc;
  logic [3:0]  w_ecause;

  // Attributes of the outstanding access needed to align the returned data.
  logic [1:0]  r_ld_off;
  logic [1:0]  r_ld_size;
  logic        r_ld_signed;
  logic        r_ld_is_load;

`ifdef MEMORY_MISALIGNED_EXCEPTION_EN
  assign w_misaligned = (load_in || store_in) &&
                        (((load_store_size_in == 2'd1) && alu_data_in[0]) ||
                         (load_store_size_in[1] && (alu_data_in[1:0] != 2'b00)));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_access = valid_in && !invalidate && !exception_in &&
                    (load_in || store_in) && !w_misaligned;
  assign w_retire = valid_in && !invalidate && !w_access;
  assign w_hold   = (r_state == S_IDLE) && stall;
  assign dbg_state = r_state;

  // An incoming exception wins; otherwise a misaligned access reports its cause.
  assign w_exc    = exception_in || w_misaligned;
  assign w_ecause = exception_in ? ecause_in :
                    (w_misaligned ? (store_in ? 4'd6 : 4'd4) : ecause_in);

  // Hazard unit must stall while an access is issuing, waiting or draining.
  assign mem_busy = ((r_state == S_IDLE) && w_access) ||
                    ((r_state == S_WAIT) && !mem_ack) ||
                    (r_state == S_DRAIN);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state and per-cycle action strobes.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_pass       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!stall) begin
          if (w_access) begin
            w_issue      = 1'b1;
            w_state_next = S_WAIT;
          end else if (w_retire) begin
            w_pass = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end else if (invalidate) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_ack) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Store lane replication and byte enables; loads read the whole word.
  always_comb begin
    w_wdata = rs2_data_in;
    w_be    = 4'b1111;
    case (load_store_size_in)
      2'd0: begin
        w_wdata = {4{rs2_data_in[7:0]}};
        w_be    = 4'b0001 << alu_data_in[1:0];
      end
      2'd1: begin
        w_wdata = {2{rs2_data_in[15:0]}};
        w_be    = 4'b0011 << {alu_data_in[1], 1'b0};
      end
      default: begin
        w_wdata = rs2_data_in;
        w_be    = 4'b1111;
      end
    endcase
    if (load_in) w_be = 4'b1111;
  end

  // Shift the addressed lane down and sign/zero extend it.
  always_comb begin
    w_lane      = mem_rdata;
    w_load_data = mem_rdata;
    case (r_ld_size)
      2'd0: begin
        w_lane      = mem_rdata >> {r_ld_off, 3'b000};
        w_load_data = {{24{r_ld_signed & w_lane[7]}}, w_lane[7:0]};
      end
      2'd1: begin
        w_lane      = mem_rdata >> {r_ld_off[1], 4'b0000};
        w_load_data = {{16{r_ld_signed & w_lane[15]}}, w_lane[15:0]};
      end
      default: begin
        w_lane      = mem_rdata;
        w_load_data = mem_rdata;
      end
    endcase
  end

  // Bus request registers: set on issue, request dropped on acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= 32'd0;
      mem_wdata       <= 32'd0;
      mem_byte_enable <= 4'd0;
      r_ld_off        <= 2'd0;
      r_ld_size       <= 2'd0;
      r_ld_signed     <= 1'b0;
      r_ld_is_load    <= 1'b0;
    end else if (w_issue) begin
      mem_req         <= 1'b1;
      mem_we          <= store_in;
      mem_addr        <= {alu_data_in[31:2], 2'b00};
      mem_wdata       <= w_wdata;
      mem_byte_enable <= w_be;
      r_ld_off        <= alu_data_in[1:0];
      r_ld_size       <= load_store_size_in;
      r_ld_signed     <= load_signed_in;
      r_ld_is_load    <= load_in;
    end else if ((r_state != S_IDLE) && mem_ack) begin
      mem_req <= 1'b0;
    end
  end

  // Writeback registers: bundle captured on issue or pass-through, load data
  // on completion; valid_out pulses only when an instruction completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out           <= 32'd0;
      next_pc_out      <= 32'd0;
      alu_data_out     <= 32'd0;
      csr_data_out     <= 32'd0;
      load_data_out    <= 32'd0;
      branch_taken_out <= 1'b0;
      csr_write_out    <= 1'b0;
      mret_out         <= 1'b0;
      wfi_out          <= 1'b0;
      valid_out        <= 1'b0;
      exception_out    <= 1'b0;
      write_select_out <= 2'd0;
      rd_address_out   <= 5'd0;
      csr_address_out  <= 12'd0;
      ecause_out       <= 4'd0;
    end else begin
      if (w_issue || w_pass) begin
        pc_out           <= pc_in;
        next_pc_out      <= next_pc_in;
        alu_data_out     <= alu_data_in;
        csr_data_out     <= csr_data_in;
        load_data_out    <= 32'd0;
        branch_taken_out <= branch_taken_in;
        csr_write_out    <= csr_write_in;
        mret_out         <= mret_in;
        wfi_out          <= wfi_in;
        exception_out    <= w_exc;
        write_select_out <= write_select_in;
        rd_address_out   <= rd_address_in;
        csr_address_out  <= csr_address_in;
        ecause_out       <= w_ecause;
      end
      if (w_done) begin
        load_data_out <= r_ld_is_load ? w_load_data : 32'd0;
      end
      if (!w_hold) begin
        valid_out <= w_pass || w_done;
      end
    end
  end

endmodule

// File: tb/tb_memory.sv
// tb_memory: directed bench for the memory stage.
module tb_memory;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
  logic        branch_taken_in, load_in, store_in, load_signed_in, csr_write_in;
  logic        mret_in, wfi_in, valid_in, exception_in;
  logic [1:0]  load_store_size_in, write_select_in;
  logic [4:0]  rd_address_in;
  logic [11:0] csr_address_in;
  logic [3:0]  ecause_in;
  logic        stall, invalidate;
  logic        mem_busy, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
  logic        branch_taken_out, csr_write_out, mret_out, wfi_out, valid_out, exception_out;
  logic [1:0]  write_select_out;
  logic [4:0]  rd_address_out;
  logic [11:0] csr_address_out;
  logic [3:0]  ecause_out;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic        sgn;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          k;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[10];

  memory dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
    .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
    .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
    .load_signed_in(load_signed_in), .csr_write_in(csr_write_in), .mret_in(mret_in),
    .wfi_in(wfi_in), .valid_in(valid_in), .exception_in(exception_in),
    .load_store_size_in(load_store_size_in), .write_select_in(write_select_in),
    .rd_address_in(rd_address_in), .csr_address_in(csr_address_in), .ecause_in(ecause_in),
    .stall(stall), .invalidate(invalidate),
    .mem_busy(mem_busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
    .csr_data_out(csr_data_out), .load_data_out(load_data_out),
    .branch_taken_out(branch_taken_out), .csr_write_out(csr_write_out),
    .mret_out(mret_out), .wfi_out(wfi_out), .valid_out(valid_out),
    .exception_out(exception_out), .write_select_out(write_select_out),
    .rd_address_out(rd_address_out), .csr_address_out(csr_address_out),
    .ecause_out(ecause_out), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0; load_signed_in = 1'b0;
    exception_in = 1'b0; ecause_in = 4'd0; load_store_size_in = 2'd0;
    branch_taken_in = 1'b0; csr_write_in = 1'b0; mret_in = 1'b0; wfi_in = 1'b0;
  endtask

  task automatic drive_mem(input logic ld, input logic st, input logic sgn,
                           input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] rs2);
    valid_in = 1'b1; load_in = ld; store_in = st; load_signed_in = sgn;
    load_store_size_in = size; alu_data_in = addr; rs2_data_in = rs2;
    pc_in = addr ^ 32'h8000_0000; rd_address_in = addr[4:0] + 5'd1;
  endtask

  // Full access: present, issue, wait k cycles for ack, check completion.
  // Starts and ends just after a rising edge.
  task automatic run_access(input vec_t v, input string tag);
    drive_mem(v.ld, v.st, v.sgn, v.size, v.addr, v.rs2);
    @(negedge clk);
    check({tag, " busy_pre"}, {31'd0, mem_busy}, 32'd1);
    next_cycle();
    idle_inputs();
    for (int i = 1; i <= v.k; i++) begin
      mem_ack   = (i == v.k);
      mem_rdata = (i == v.k) ? v.rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      check({tag, " req"}, {31'd0, mem_req}, 32'd1);
      check({tag, " addr"}, mem_addr, v.e_addr);
      check({tag, " be"}, {28'd0, mem_byte_enable}, {28'd0, v.e_be});
      check({tag, " we"}, {31'd0, mem_we}, {31'd0, v.st});
      if (v.st) check({tag, " wdata"}, mem_wdata, v.e_wdata);
      check({tag, " busy_wait"}, {31'd0, mem_busy}, {31'd0, (i != v.k)});
      check({tag, " valid_wait"}, {31'd0, valid_out}, 32'd0);
      next_cycle();
    end
    mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    check({tag, " valid_done"}, {31'd0, valid_out}, 32'd1);
    check({tag, " req_done"}, {31'd0, mem_req}, 32'd0);
    check({tag, " busy_done"}, {31'd0, mem_busy}, 32'd0);
    check({tag, " pc_out"}, pc_out, v.addr ^ 32'h8000_0000);
    if (v.ld) check({tag, " load_data"}, load_data_out, v.e_load);
    next_cycle();
    @(negedge clk);
    check({tag, " valid_pulse_end"}, {31'd0, valid_out}, 32'd0);
    next_cycle();
  endtask

  initial begin
    // Vector table: ld st sgn size addr rs2 rdata k | addr be wdata load
    vecs[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0103, 32'h1234_5678, 32'h0, 1,
                32'h0000_0100, 4'b1000, 32'h7878_7878, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0002, 32'h0, 32'h0080_0000, 1,
                32'h0000_0000, 4'b1111, 32'h0, 32'hFFFF_FF80};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0002, 32'h0, 32'h0080_0000, 2,
                32'h0000_0000, 4'b1111, 32'h0, 32'h0000_0080};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0020, 32'h0, 32'h1357_2468, 4,
                32'h0000_0020, 4'b1111, 32'h0, 32'h1357_2468};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 2'd1, 32'h0000_0042, 32'h0, 32'h8001_1234, 1,
                32'h0000_0040, 4'b1111, 32'h0, 32'hFFFF_8001};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_0040, 32'h0, 32'hAAAA_F00F, 1,
                32'h0000_0040, 4'b1111, 32'h0, 32'h0000_F00F};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0006, 32'hAAAA_BEEF, 32'h0, 2,
                32'h0000_0004, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1,
                32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0201, 32'h0, 32'h0000_7F00, 1,
                32'h0000_0200, 4'b1111, 32'h0, 32'h0000_007F};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0300, 32'h0000_00A5, 32'h0, 1,
                32'h0000_0300, 4'b0001, 32'hA5A5_A5A5, 32'h0};

    // Reset
    reset = 1'b1; stall = 1'b0; invalidate = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    pc_in = 32'd0; next_pc_in = 32'd0; alu_data_in = 32'd0; rs2_data_in = 32'd0;
    csr_data_in = 32'd0; write_select_in = 2'd0; rd_address_in = 5'd0; csr_address_in = 12'd0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req", {31'd0, mem_req}, 32'd0);
    check("rst be", {28'd0, mem_byte_enable}, 32'd0);
    check("rst valid", {31'd0, valid_out}, 32'd0);
    check("rst state", {30'd0, dbg_state}, 32'd0);
    check("rst pc_out", pc_out, 32'd0);
    reset = 1'b0;
    next_cycle();

    // Table-driven accesses
    for (int i = 0; i < 10; i++) run_access(vecs[i], $sformatf("vec%0d", i));

    // Non-memory instruction: one-cycle pass-through
    valid_in = 1'b1; pc_in = 32'h400; next_pc_in = 32'h404; alu_data_in = 32'h55;
    csr_data_in = 32'h66; branch_taken_in = 1'b1; write_select_in = 2'd2;
    rd_address_in = 5'd7; csr_address_in = 12'h305; csr_write_in = 1'b1; wfi_in = 1'b1;
    @(negedge clk);
    check("nomem busy", {31'd0, mem_busy}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("nomem valid", {31'd0, valid_out}, 32'd1);
    check("nomem pc", pc_out, 32'h400);
    check("nomem next_pc", next_pc_out, 32'h404);
    check("nomem alu", alu_data_out, 32'h55);
    check("nomem csr_data", csr_data_out, 32'h66);
    check("nomem rd", {27'd0, rd_address_out}, 32'd7);
    check("nomem csr_addr", {20'd0, csr_address_out}, 32'h305);
    check("nomem ctl", {28'd0, branch_taken_out, csr_write_out, wfi_out, mret_out}, 32'hE);
    check("nomem wsel", {30'd0, write_select_out}, 32'd2);
    check("nomem req", {31'd0, mem_req}, 32'd0);
    next_cycle();

    // Stall holds outputs and blocks issue
    valid_in = 1'b1; pc_in = 32'h500;
    next_cycle();
    stall = 1'b1;
    drive_mem(1'b1, 1'b0, 1'b0, 2'd2, 32'h40, 32'h0);
    @(negedge clk);
    check("stall retired", {31'd0, valid_out}, 32'd1);
    check("stall busy", {31'd0, mem_busy}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("stall hold valid", {31'd0, valid_out}, 32'd1);
    check("stall hold pc", pc_out, 32'h500);
    check("stall no req", {31'd0, mem_req}, 32'd0);
    check("stall state", {30'd0, dbg_state}, 32'd0);
    next_cycle();
    stall = 1'b0;
    idle_inputs();
    next_cycle();
    @(negedge clk);
    check("stall bubble", {31'd0, valid_out}, 32'd0);
    next_cycle();

    // Incoming exception: no bus access, cause passed through
    drive_mem(1'b1, 1'b0, 1'b0, 2'd2, 32'h80, 32'h0);
    exception_in = 1'b1; ecause_in = 4'd5;
    @(negedge clk);
    check("exc busy", {31'd0, mem_busy}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("exc req", {31'd0, mem_req}, 32'd0);
    check("exc flag", {31'd0, exception_out}, 32'd1);
    check("exc cause", {28'd0, ecause_out}, 32'd5);
    check("exc valid", {31'd0, valid_out}, 32'd1);
    next_cycle();

`ifdef MEMORY_MISALIGNED_EXCEPTION_EN
    drive_mem(1'b1, 1'b0, 1'b0, 2'd2, 32'h1002, 32'h0);
    @(negedge clk);
    check("mis_ld busy", {31'd0, mem_busy}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("mis_ld req", {31'd0, mem_req}, 32'd0);
    check("mis_ld exc", {31'd0, exception_out}, 32'd1);
    check("mis_ld cause", {28'd0, ecause_out}, 32'd4);
    next_cycle();
    drive_mem(1'b0, 1'b1, 1'b0, 2'd1, 32'h1001, 32'h0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("mis_st req", {31'd0, mem_req}, 32'd0);
    check("mis_st exc", {31'd0, exception_out}, 32'd1);
    check("mis_st cause", {28'd0, ecause_out}, 32'd6);
    next_cycle();
`else
    begin
      vec_t mv;
      mv = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_1002, 32'h0, 32'h89AB_CDEF, 1,
             32'h0000_1000, 4'b1111, 32'h0, 32'h89AB_CDEF};
      run_access(mv, "mis_ld");
      mv = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_1001, 32'h0000_ABCD, 32'h0, 1,
             32'h0000_1000, 4'b0011, 32'hABCD_ABCD, 32'h0};
      run_access(mv, "mis_st");
    end
`endif

    // Invalidate while waiting: drain without completing
    drive_mem(1'b1, 1'b0, 1'b0, 2'd2, 32'h50, 32'h0);
    next_cycle();
    idle_inputs();
    invalidate = 1'b1;
    @(negedge clk);
    check("inv wait state", {30'd0, dbg_state}, 32'd1);
    check("inv busy0", {31'd0, mem_busy}, 32'd1);
    next_cycle();
    invalidate = 1'b0;
    @(negedge clk);
    check("inv drain state", {30'd0, dbg_state}, 32'd2);
    check("inv drain req", {31'd0, mem_req}, 32'd1);
    check("inv drain busy", {31'd0, mem_busy}, 32'd1);
    check("inv drain valid", {31'd0, valid_out}, 32'd0);
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("inv ack busy", {31'd0, mem_busy}, 32'd1);
    check("inv ack req", {31'd0, mem_req}, 32'd1);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    check("inv end state", {30'd0, dbg_state}, 32'd0);
    check("inv end req", {31'd0, mem_req}, 32'd0);
    check("inv end valid", {31'd0, valid_out}, 32'd0);
    check("inv end busy", {31'd0, mem_busy}, 32'd0);
    next_cycle();

    // Reset in the middle of a wait abandons the access immediately
    drive_mem(1'b1, 1'b0, 1'b0, 2'd2, 32'h30, 32'h0);
    next_cycle();
    idle_inputs();
    check("rstw req before", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rstw req", {31'd0, mem_req}, 32'd0);
    check("rstw valid", {31'd0, valid_out}, 32'd0);
    check("rstw state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    next_cycle();
    run_access(vecs[3], "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
